rat_ckpt: RTL and testbench
===========================

Name: rat_ckpt

Overview:
Parametrised register alias table: the rename map for the dispatch stage, with branch checkpoints. Per architectural register it holds a speculative bit and a ROB tag, and serves N_SRC source lookups per cycle. Unlike the single-level flush-only map it replaces, it keeps up to N_CKPT in-order snapshots, so a mispredict restores the exact map instead of flushing to all-retired. It sits between decode and the ROB/IIQ/LSQ dispatch handshake.

Parameters:
N_ARCH, 32, architectural registers; x0 is hardwired never-speculative
ARF_ID_W, $clog2(N_ARCH), arch register id width
ROB_ID_W, 4, ROB tag width
N_SRC, 2, lookup ports
N_CKPT, 4, checkpoint slots; power of two, at least 2
CKPT_ID_W, $clog2(N_CKPT), checkpoint id width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
lookup_arf_id  in  N_SRC*ARF_ID_W  source register ids
lookup_spec  out  N_SRC  1 = value lives in the ROB; 0 = value lives in the ARF
lookup_rob_id  out  N_SRC*ROB_ID_W  tag currently mapped to the source
rename_valid  in  1  write a destination mapping
rename_arf_id  in  ARF_ID_W  destination register
rename_rob_id  in  ROB_ID_W  ROB tag allocated to the destination
retire_valid  in  1  ROB head is retiring
retire_arf_id  in  ARF_ID_W  destination register of the retiring instruction
retire_rob_id  in  ROB_ID_W  ROB tag of the retiring instruction
ckpt_alloc_valid  in  1  take a snapshot (branch dispatch)
ckpt_alloc_ready  out  1  a free slot exists
ckpt_alloc_id  out  CKPT_ID_W  slot that the alloc uses
ckpt_free_valid  in  1  oldest checkpoint resolved correctly; free it
ckpt_restore_valid  in  1  mispredict
ckpt_restore_id  in  CKPT_ID_W  checkpoint to restore
flush  in  1  full flush: map all-retired, all checkpoints freed
ckpt_count  out  $clog2(N_CKPT+1)  live checkpoints

Behaviour:
- Reset (sync, highest priority): all spec=0, tags=0, head=tail=0, ckpt_count=0, ckpt_alloc_ready=1, ckpt_alloc_id=0.
- Lookups: combinational from the registered map. There is no same-cycle rename bypass; dispatch owns intra-group dependences. A lookup of id 0 always returns spec=0.
- Rename: at the clock edge, spec[rd]=1 and tag[rd]=rename_rob_id. Ignored when rd=0.
- Retire: clears spec[a] only if tag[a]==retire_rob_id (the register was not renamed again).
  - The same compare-and-clear applies to every live checkpoint, so a restore never resurrects a retired tag.
  - If rename and retire hit the same register in the same cycle, rename wins.
- Checkpoints form a circular FIFO: head = oldest, tail = next to allocate; ckpt_alloc_id = tail.
- Alloc: accepted when valid && ready.
  - The snapshot is the post-update map of the same cycle (it includes that cycle's rename and retire).
  - tail++ on accept.
  - ready = (ckpt_count != N_CKPT), computed from registered state. When full, alloc is ignored even if a free occurs in the same cycle.
- Free: head++ and count--. Ignored when count==0.
- Restore (precedence over rename and alloc; both are dropped that cycle):
  - map := ckpt[restore_id] with the same-cycle retire applied.
  - Checkpoint restore_id and all younger are freed: tail := restore_id.
  - A same-cycle free is still honoured: count := ((restore_id - head) mod N_CKPT) minus free.
  - If restore_id == head, count becomes 0.
  - If restore_id is not live, the result is undefined; an assertion fires in simulation.
- Flush: all spec=0, head=tail=0, count=0. Tags are retained. Flush overrides restore, rename, alloc and free; the same-cycle retire is moot.
- Priority: rst > flush > restore > {retire, free, rename, alloc}.
- Wrap-around: head and tail are CKPT_ID_W-bit counters. count disambiguates full from empty.

Test Plan:
1. Reset, then lookup x5 -> spec=0, count=0, ready=1, alloc_id=0.
2. Rename x5->tag 3 then lookup x5 -> spec=1, tag=3. Retire (x5, tag 3) -> spec=0. Rename x5->7, then retire (x5, tag 3) -> spec stays 1, tag=7.
3. Rename x5->3 plus alloc in the same cycle (slot 0). Rename x5->9. Restore 0 -> x5 spec=1, tag=3; count=0; alloc_id=0.
4. Alloc 4 times -> count=4, ready=0. A 5th alloc with a concurrent free -> ignored, count=3. Next alloc_id=0 (wrap).
5. Checkpoint holds x6->tag 2. Retire (x6, 2), then restore -> x6 spec=0.
6. Flush asserted with restore and rename in the same cycle -> all spec=0, count=0. Rename x0->4 -> lookup x0 spec=0.

Source files
------------

// File: rtl/rat_ckpt.sv
// Register alias table with an in-order FIFO of branch checkpoints.
// A mispredict restores the map to a snapshot; retires clear the live map and all snapshots.
module rat_ckpt #(
  parameter int N_ARCH    = 32,
  parameter int ARF_ID_W  = $clog2(N_ARCH),
  parameter int ROB_ID_W  = 4,
  parameter int N_SRC     = 2,
  parameter int N_CKPT    = 4,
  parameter int CKPT_ID_W = $clog2(N_CKPT)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_SRC*ARF_ID_W-1:0]   i_lookup_arf_id,
  output logic [N_SRC-1:0]            o_lookup_spec,
  output logic [N_SRC*ROB_ID_W-1:0]   o_lookup_rob_id,
  input  logic                        i_rename_valid,
  input  logic [ARF_ID_W-1:0]         i_rename_arf_id,
  input  logic [ROB_ID_W-1:0]         i_rename_rob_id,
  input  logic                        i_retire_valid,
  input  logic [ARF_ID_W-1:0]         i_retire_arf_id,
  input  logic [ROB_ID_W-1:0]         i_retire_rob_id,
  input  logic                        i_ckpt_alloc_valid,
  output logic                        o_ckpt_alloc_ready,
  output logic [CKPT_ID_W-1:0]        o_ckpt_alloc_id,
  input  logic                        i_ckpt_free_valid,
  input  logic                        i_ckpt_restore_valid,
  input  logic [CKPT_ID_W-1:0]        i_ckpt_restore_id,
  input  logic                        i_flush,
  output logic [$clog2(N_CKPT+1)-1:0] o_ckpt_count
);
  localparam int CNT_W = $clog2(N_CKPT + 1);

  logic [N_ARCH-1:0]   r_spec;
  logic [ROB_ID_W-1:0] r_tag [N_ARCH];
  logic [N_ARCH-1:0]   r_ckptSpec [N_CKPT];
  logic [ROB_ID_W-1:0] r_ckptTag [N_CKPT][N_ARCH];
  logic [CKPT_ID_W-1:0] r_head, r_tail;
  logic [CNT_W-1:0]     r_count;

  logic [N_ARCH-1:0]    w_nextSpec;
  logic [ROB_ID_W-1:0]  w_nextTag [N_ARCH];
  logic [N_ARCH-1:0]    w_nextCkptSpec [N_CKPT];
  logic [ROB_ID_W-1:0]  w_nextCkptTag [N_CKPT][N_ARCH];
  logic [CKPT_ID_W-1:0] w_nextHead, w_nextTail, w_restoreDist;
  logic [CNT_W-1:0]     w_nextCount;
  logic                 w_ready, w_allocFire, w_freeFire, w_restoreLive;

  assign w_ready       = (r_count != CNT_W'(N_CKPT));
  assign w_allocFire   = i_ckpt_alloc_valid && w_ready && !i_ckpt_restore_valid;
  assign w_freeFire    = i_ckpt_free_valid && (r_count != '0);
  assign w_restoreDist = i_ckpt_restore_id - r_head;
  assign w_restoreLive = (CNT_W'(w_restoreDist) < r_count);

  assign o_ckpt_alloc_ready = w_ready;
  assign o_ckpt_alloc_id    = r_tail;
  assign o_ckpt_count       = r_count;

  always_comb begin
    o_lookup_spec   = '0;
    o_lookup_rob_id = '0;
    for (int s = 0; s < N_SRC; s++) begin
      o_lookup_spec[s] = (i_lookup_arf_id[s*ARF_ID_W +: ARF_ID_W] != '0) &&
                         r_spec[i_lookup_arf_id[s*ARF_ID_W +: ARF_ID_W]];
      o_lookup_rob_id[s*ROB_ID_W +: ROB_ID_W] = r_tag[i_lookup_arf_id[s*ARF_ID_W +: ARF_ID_W]];
    end
  end

  // Retire is checked against the source map's tag before rename overwrites it, so rename wins.
  always_comb begin
    for (int a = 0; a < N_ARCH; a++) begin
      w_nextSpec[a] = r_spec[a];
      w_nextTag[a]  = r_tag[a];
      if (i_ckpt_restore_valid) begin
        w_nextSpec[a] = r_ckptSpec[i_ckpt_restore_id][a];
        w_nextTag[a]  = r_ckptTag[i_ckpt_restore_id][a];
      end
      if (i_retire_valid && (i_retire_arf_id == ARF_ID_W'(a)) &&
          (w_nextTag[a] == i_retire_rob_id))
        w_nextSpec[a] = 1'b0;
      if (!i_ckpt_restore_valid && i_rename_valid && (i_rename_arf_id == ARF_ID_W'(a)) && (a != 0)) begin
        w_nextSpec[a] = 1'b1;
        w_nextTag[a]  = i_rename_rob_id;
      end
      if (a == 0)
        w_nextSpec[a] = 1'b0;
    end
    for (int c = 0; c < N_CKPT; c++) begin
      for (int a = 0; a < N_ARCH; a++) begin
        w_nextCkptTag[c][a]  = r_ckptTag[c][a];
        w_nextCkptSpec[c][a] = r_ckptSpec[c][a] &&
          !(i_retire_valid && (i_retire_arf_id == ARF_ID_W'(a)) &&
            (r_ckptTag[c][a] == i_retire_rob_id));
      end
    end
    if (w_allocFire) begin
      w_nextCkptSpec[r_tail] = w_nextSpec;
      w_nextCkptTag[r_tail]  = w_nextTag;
    end
  end

  always_comb begin
    w_nextHead = r_head + CKPT_ID_W'(w_freeFire);
    if (i_ckpt_restore_valid) begin
      w_nextTail  = i_ckpt_restore_id;
      w_nextCount = (w_restoreDist == '0) ? '0 : CNT_W'(w_restoreDist) - CNT_W'(w_freeFire);
    end else begin
      w_nextTail  = r_tail + CKPT_ID_W'(w_allocFire);
      w_nextCount = r_count + CNT_W'(w_allocFire) - CNT_W'(w_freeFire);
    end
  end

  // Flush keeps tags and snapshot contents; only the speculative bits and FIFO pointers clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_spec  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int a = 0; a < N_ARCH; a++) r_tag[a] <= '0;
      for (int c = 0; c < N_CKPT; c++) begin
        r_ckptSpec[c] <= '0;
        for (int a = 0; a < N_ARCH; a++) r_ckptTag[c][a] <= '0;
      end
    end else if (i_flush) begin
      r_spec  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_spec     <= w_nextSpec;
      r_tag      <= w_nextTag;
      r_ckptSpec <= w_nextCkptSpec;
      r_ckptTag  <= w_nextCkptTag;
      r_head     <= w_nextHead;
      r_tail     <= w_nextTail;
      r_count    <= w_nextCount;
    end
  end

  restoreLiveCheck: assert property (@(posedge clk) disable iff (rst)
    (i_ckpt_restore_valid && !i_flush) |-> w_restoreLive);
endmodule

// File: tb/tb_rat_ckpt.sv
// Directed bench for rat_ckpt: rename/retire, checkpoint alloc/free/restore, wrap and flush.
// Expected values are hand-computed constants for each step.
module tb_rat_ckpt;
  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] lookupArfId;
  logic [1:0] lookupSpec;
  logic [7:0] lookupRobId;
  logic       renameValid;
  logic [4:0] renameArfId;
  logic [3:0] renameRobId;
  logic       retireValid;
  logic [4:0] retireArfId;
  logic [3:0] retireRobId;
  logic       allocValid, allocReady;
  logic [1:0] allocId;
  logic       freeValid, restoreValid;
  logic [1:0] restoreId;
  logic       flush;
  logic [2:0] ckptCount;

  int testsRun = 0;
  int testsFailed = 0;

  rat_ckpt dut (
    .clk(clk), .rst(rst),
    .i_lookup_arf_id(lookupArfId), .o_lookup_spec(lookupSpec), .o_lookup_rob_id(lookupRobId),
    .i_rename_valid(renameValid), .i_rename_arf_id(renameArfId), .i_rename_rob_id(renameRobId),
    .i_retire_valid(retireValid), .i_retire_arf_id(retireArfId), .i_retire_rob_id(retireRobId),
    .i_ckpt_alloc_valid(allocValid), .o_ckpt_alloc_ready(allocReady), .o_ckpt_alloc_id(allocId),
    .i_ckpt_free_valid(freeValid), .i_ckpt_restore_valid(restoreValid),
    .i_ckpt_restore_id(restoreId), .i_flush(flush), .o_ckpt_count(ckptCount)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    testsRun++;
    if (observed != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic idleInputs();
    renameValid = 0; renameArfId = 0; renameRobId = 0;
    retireValid = 0; retireArfId = 0; retireRobId = 0;
    allocValid = 0; freeValid = 0; restoreValid = 0; restoreId = 0; flush = 0;
  endtask

  // Apply the currently driven controls for one clock edge, then return to idle.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    idleInputs();
  endtask

  task automatic doRename(input logic [4:0] a, input logic [3:0] t);
    renameValid = 1; renameArfId = a; renameRobId = t;
  endtask

  task automatic doRetire(input logic [4:0] a, input logic [3:0] t);
    retireValid = 1; retireArfId = a; retireRobId = t;
  endtask

  task automatic checkReg(input string tag, input logic [4:0] a, input int expSpec, input int expTag);
    lookupArfId = {5'd0, a};
    #1;
    checkOutput({tag, ".spec"}, int'(lookupSpec[0]), expSpec);
    checkOutput({tag, ".tag"}, int'(lookupRobId[3:0]), expTag);
  endtask

  initial begin
    idleInputs();
    lookupArfId = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    // Reset state
    checkReg("rst_x5", 5, 0, 0);
    checkOutput("rst_count", int'(ckptCount), 0);
    checkOutput("rst_ready", int'(allocReady), 1);
    checkOutput("rst_allocId", int'(allocId), 0);

    // Rename / retire compare-and-clear
    doRename(5, 3); applyStimulus();
    checkReg("ren_x5", 5, 1, 3);
    doRetire(5, 3); applyStimulus();
    checkReg("ret_x5", 5, 0, 3);
    doRename(5, 7); applyStimulus();
    doRetire(5, 3); applyStimulus();
    checkReg("staleRet_x5", 5, 1, 7);

    // Second lookup port reads x5 while port 0 reads x0
    lookupArfId = {5'd5, 5'd0};
    #1;
    checkOutput("port1_spec", int'(lookupSpec[1]), 1);
    checkOutput("port1_tag", int'(lookupRobId[7:4]), 7);
    checkOutput("port0_x0_spec", int'(lookupSpec[0]), 0);

    // Rename and retire of the same register in one cycle: rename wins
    doRename(10, 4); applyStimulus();
    doRename(10, 6); doRetire(10, 4); applyStimulus();
    checkReg("renWins_x10", 10, 1, 6);

    // Snapshot includes the same-cycle rename, then restore it
    doRename(5, 3); allocValid = 1; applyStimulus();
    checkOutput("alloc_count", int'(ckptCount), 1);
    checkOutput("alloc_id", int'(allocId), 1);
    doRename(5, 9); applyStimulus();
    checkReg("ren9_x5", 5, 1, 9);
    restoreValid = 1; restoreId = 0; applyStimulus();
    checkReg("restore_x5", 5, 1, 3);
    checkOutput("restore_count", int'(ckptCount), 0);
    checkOutput("restore_allocId", int'(allocId), 0);

    // Fill all slots, then full alloc with concurrent free
    for (int i = 0; i < 4; i++) begin
      allocValid = 1; applyStimulus();
    end
    checkOutput("full_count", int'(ckptCount), 4);
    checkOutput("full_ready", int'(allocReady), 0);
    checkOutput("full_allocId", int'(allocId), 0);
    allocValid = 1; freeValid = 1; applyStimulus();
    checkOutput("fullFree_count", int'(ckptCount), 3);
    checkOutput("fullFree_allocId", int'(allocId), 0);
    checkOutput("fullFree_ready", int'(allocReady), 1);
    allocValid = 1; applyStimulus();
    checkOutput("wrap_allocId", int'(allocId), 1);
    checkOutput("wrap_count", int'(ckptCount), 4);

    // Retire clears the live checkpoint too, so restore does not resurrect it
    flush = 1; applyStimulus();
    checkOutput("flush_count", int'(ckptCount), 0);
    doRename(6, 2); allocValid = 1; applyStimulus();
    doRetire(6, 2); applyStimulus();
    checkReg("ret_x6", 6, 0, 2);
    doRename(6, 5); applyStimulus();
    checkReg("ren_x6", 6, 1, 5);
    restoreValid = 1; restoreId = 0; applyStimulus();
    checkReg("restoreRet_x6", 6, 0, 2);

    // Flush overrides same-cycle restore and rename
    doRename(7, 8); allocValid = 1; applyStimulus();
    checkOutput("pre_flush_count", int'(ckptCount), 1);
    flush = 1; restoreValid = 1; restoreId = 0; doRename(9, 1); applyStimulus();
    checkReg("flush_x7", 7, 0, 8);
    checkReg("flush_x9", 9, 0, 0);
    checkOutput("flush2_count", int'(ckptCount), 0);
    checkOutput("flush2_allocId", int'(allocId), 0);
    checkOutput("flush2_ready", int'(allocReady), 1);

    // x0 is never speculative
    doRename(0, 4); applyStimulus();
    checkReg("x0", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
